// File: rtl/aes_round_sequencer_if.sv
// Start/busy/done handshake and round-control bundle between the host side
// and the AES round sequencer.
interface aes_round_sequencer_if;
    logic       start;
    logic       stall;
    logic       abort;
    logic       busy;
    logic       load_en;
    logic       rnd_en;
    logic [3:0] rnd_num;
    logic [7:0] rcon;
    logic       first_rnd;
    logic       final_rnd;
    logic       done;

    modport master (
        output start, stall, abort,
        input  busy, load_en, rnd_en, rnd_num, rcon, first_rnd, final_rnd, done
    );

    modport slave (
        input  start, stall, abort,
        output busy, load_en, rnd_en, rnd_num, rcon, first_rnd, final_rnd, done
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Control FSM that walks one AES-128 block through LOAD, the cipher rounds and
// a done pulse, generating round number, round constant and first/final flags.
module aes_round_sequencer #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_round_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } state_t;

    localparam logic [3:0] LAST_ROUND   = 4'(NUM_ROUNDS);
    localparam logic [3:0] PENULT_ROUND = 4'(NUM_ROUNDS - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] rnd_q;
    logic [7:0] rcon_q;
    logic       advance;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign advance = (state == ROUND) && !bus.stall;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Round number and round constant only move on a committed ROUND cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rnd_q  <= '0;
            rcon_q <= '0;
        end else if (state == LOAD) begin
            rnd_q  <= 4'd1;
            rcon_q <= 8'h01;
        end else if (advance) begin
            rnd_q  <= rnd_q + 4'd1;
            rcon_q <= xtime(rcon_q);
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = LOAD;
            LOAD:    state_next = bus.abort ? IDLE : ROUND;
            ROUND: begin
                if (bus.abort)                                 state_next = IDLE;
                else if (!bus.stall && rnd_q == PENULT_ROUND)  state_next = FINAL;
            end
            FINAL: begin
                if (bus.abort)       state_next = IDLE;
                else if (!bus.stall) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Everything but rnd_en is decoded from registered state alone.
    always_comb begin
        bus.busy      = 1'b0;
        bus.load_en   = 1'b0;
        bus.rnd_en    = 1'b0;
        bus.rnd_num   = '0;
        bus.rcon      = '0;
        bus.first_rnd = 1'b0;
        bus.final_rnd = 1'b0;
        bus.done      = 1'b0;
        unique case (state)
            LOAD: begin
                bus.busy    = 1'b1;
                bus.load_en = 1'b1;
            end
            ROUND: begin
                bus.busy      = 1'b1;
                bus.rnd_en    = !bus.stall;
                bus.rnd_num   = rnd_q;
                bus.rcon      = rcon_q;
                bus.first_rnd = (rnd_q == 4'd1);
            end
            FINAL: begin
                bus.busy      = 1'b1;
                bus.rnd_en    = !bus.stall;
                bus.rnd_num   = LAST_ROUND;
                bus.rcon      = rcon_q;
                bus.final_rnd = 1'b1;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Control FSM that sequences one AES-128 encryption block through the round datapath and the on-the-fly key expansion unit. On a start request it issues a load strobe, steps through NUM_ROUNDS rounds while presenting the round number, round constant and first/final-round flags, and honours a datapath stall. It then pulses done. It sits between the top-level host interface and the round/key-expansion datapath, and replaces free-running round counters with a start/busy/done handshake.

## Interface
- NUM_ROUNDS, 10, number of cipher rounds after the initial AddRoundKey; legal range 2..10.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a block; sampled only in IDLE.
- stall  in  1  datapath/key-expansion not ready; freezes round progress.
- abort  in  1  cancel the block in progress; no done is issued.
- busy  out  1  high in LOAD, ROUND and FINAL.
- load_en  out  1  one-cycle strobe: capture plaintext/key and perform the initial AddRoundKey.
- rnd_en  out  1  round executes this cycle.
- rnd_num  out  4  current round, 1..NUM_ROUNDS; 0 outside ROUND/FINAL.
- rcon  out  8  round constant for this round's key expansion; 0x00 outside ROUND/FINAL.
- first_rnd  out  1  high while rnd_num==1.
- final_rnd  out  1  high in FINAL (datapath skips MixColumns).
- done  out  1  one-cycle pulse after the final round completes.

## Operation
- States: IDLE, LOAD, ROUND, FINAL, DONE.
- IDLE:
  - start=1 → LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - load_en=1.
  - Always advances to ROUND next cycle; stall is ignored.
  - Sets rnd_num=1 and rcon=0x01.
- ROUND:
  - rnd_en = ~stall.
  - If stall=0: rnd_num increments, and rcon advances by xtime: rcon_next = {rcon[6:0],1'b0} ^ (rcon[7] ? 0x1B : 0x00).
  - When the round just executed is NUM_ROUNDS-1 → FINAL.
  - If stall=1: state, rnd_num and rcon hold.
- FINAL:
  - rnd_num=NUM_ROUNDS and final_rnd=1.
  - rnd_en = ~stall.
  - If stall=0 → DONE; if stall=1, hold.
- DONE:
  - done=1 and busy=0.
  - Unconditionally → IDLE.
  - start in DONE is ignored.
- Round-constant sequence for rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- first_rnd and final_rnd are never both high, because NUM_ROUNDS≥2.
- abort:
  - In LOAD, ROUND or FINAL: → IDLE next cycle with all outputs zero and no done.
  - abort has priority over stall.
  - abort is ignored in IDLE and DONE.
- start while busy is ignored and is not queued.
- rst has priority over everything.
  - In any state, rst → IDLE next cycle.
  - Reset value of every output: busy 0, load_en 0, rnd_en 0, rnd_num 0, rcon 0x00, first_rnd 0, final_rnd 0, done 0.
- Output timing:
  - All outputs except rnd_en are decoded from registered state only.
  - rnd_en is the one combinational path: (state==ROUND | state==FINAL) & ~stall.

## Timing
- Latency with no stalls, taking the cycle start is sampled in IDLE as cycle 0:
  - Cycle 1: LOAD.
  - Cycles 2..NUM_ROUNDS+1: rounds 1..NUM_ROUNDS.
  - Cycle NUM_ROUNDS+2: done (cycle 12 for the default).
  - Cycle NUM_ROUNDS+3: IDLE again; this is the earliest next start, so the throughput is one block per 13 cycles.
- Each stalled cycle in ROUND/FINAL adds exactly one cycle of latency.
- Stall on the cycle FINAL is entered holds final_rnd and rnd_num=NUM_ROUNDS until stall drops.
- The datapath commits a round only on cycles with rnd_en=1. rnd_num and rcon are stable for the whole cycle and change only on the edge after a cycle with rnd_en=1.

## Test plan
- Nominal block:
  - Stimulus: rst, then a start pulse at cycle 0.
  - Required: load_en at cycle 1; rnd_en cycles 2..11 with rnd_num 1..10 and rcon 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36; first_rnd at cycle 2 only; final_rnd at cycle 11 only; done at cycle 12 only; busy high over cycles 1..11.
- Stall:
  - Stimulus: stall=1 for 3 cycles during round 4, then 2 cycles on the first FINAL cycle.
  - Required: rnd_num/rcon hold at 4/0x08 with rnd_en=0, then at 10/0x36 with final_rnd=1; done at cycle 17; stall asserted during LOAD has no effect.
- Abort:
  - Stimulus: abort at round 6.
  - Required: next cycle IDLE with all outputs 0 and no done pulse; a start two cycles later runs a full nominal block from rcon 0x01.
- Ignored starts:
  - Stimulus: start held high continuously.
  - Required: blocks begin every 13 cycles; a start pulse during ROUND or DONE does not extend or restart the block.
- Reset mid-operation:
  - Stimulus: rst=1 during round 8 with stall=1.
  - Required: all outputs at their reset values on the next cycle; rst asserted together with start keeps the FSM in IDLE.
- Parameter:
  - Stimulus: NUM_ROUNDS=2.
  - Required: round 1 with first_rnd and rcon 0x01; round 2 with final_rnd and rcon 0x02; done at cycle 4.
